axis_len_keep_gen: RTL and testbench
====================================

Name: axis_len_keep_gen

Overview:
- Length-driven AXI-Stream framer for the 10GbE datapath.
- Accepts one byte-length command per frame, then passes raw data beats through a single registered output stage.
- Generates per-beat tkeep and tlast from the running remaining-byte count.
- Parametrised successor of the fixed 8-byte count-to-keep decoder: generic data width, selectable keep alignment, and a sequential frame counter with handshakes.

Parameters:
- C_DATA_BYTES, 8: bytes per beat; power of two, 1..64.
- C_LEN_WIDTH, 16: width of the frame-length command in bytes.
- C_KEEP_MSB_FIRST, 1:
  - 1: the first valid byte is keep[C_DATA_BYTES-1], so a 1-byte partial beat gives 8'b1000_0000.
  - 0: LSB-first, so a 1-byte partial beat gives 8'b0000_0001.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- len_tdata  in  C_LEN_WIDTH  frame length in bytes
- len_tvalid  in  1  length command valid
- len_tready  out  1  length command accepted
- s_axis_tdata  in  8*C_DATA_BYTES  raw data beat
- s_axis_tvalid  in  1  data valid
- s_axis_tready  out  1  data accepted
- m_axis_tdata  out  8*C_DATA_BYTES  registered data
- m_axis_tkeep  out  C_DATA_BYTES  byte enables
- m_axis_tlast  out  1  last beat of frame
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  downstream ready
- busy  out  1  high while in RUN state or while the output register holds a beat
- zero_len  out  1  one-cycle pulse when a length-0 command is dropped

Behaviour:
- Reset (synchronous, rst=1 at a rising clk edge):
  - state=IDLE, remaining=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0.
  - zero_len=0, busy=0, len_tready=0 during the reset cycle.
  - A reset mid-frame discards the held beat and the remaining count. No tlast is emitted.
- State machine, IDLE / RUN:
  - IDLE: len_tready=1, s_axis_tready=0.
    - On len_tvalid with L=0: the command is consumed, zero_len pulses for 1 cycle, state stays IDLE.
    - On len_tvalid with L>0: remaining<=L, go to RUN.
  - RUN: len_tready=0, s_axis_tready = (!m_axis_tvalid || m_axis_tready).
- Beat transfer: on each s_axis handshake in RUN, load the output register with the data and:
  - If remaining > C_DATA_BYTES: tkeep = all ones, tlast=0, remaining -= C_DATA_BYTES.
  - If remaining <= C_DATA_BYTES: tkeep = mask(remaining), tlast=1, remaining<=0, state goes to IDLE.
- mask(n): n contiguous ones, aligned per C_KEEP_MSB_FIRST; n ranges 1..C_DATA_BYTES.
- Output register:
  - m_axis_tvalid sets on load.
  - Clears on an m_axis handshake with no simultaneous load.
  - A simultaneous drain and load keeps tvalid=1 with the new beat (full throughput, 1 beat/cycle).
  - While tvalid=1 and tready=0, data/keep/last are held stable.
- Latency: input beat to m_axis_tvalid is 1 cycle.
- Inter-frame gap: a new length command is accepted no earlier than the cycle after the last beat is loaded, giving a minimum 1-cycle bubble between frames.
- Width: remaining is C_LEN_WIDTH bits and never underflows. The beat count is ceil(L/C_DATA_BYTES).
- s_axis beats presented while in IDLE are not accepted.
- busy = (state==RUN) || m_axis_tvalid.

Optional Feature:
- Macro: AXIS_LEN_KEEP_STATS_EN.
- Defined:
  - Adds output ports stat_frames[31:0] and stat_bytes[31:0], both reset to 0.
  - stat_frames increments on each m_axis handshake with tlast=1.
  - stat_bytes adds popcount(tkeep) on every m_axis handshake.
  - Both counters wrap modulo 2^32.
- Undefined: the ports and counters are absent. Datapath behaviour is identical.

Decomposition:
- Shared package axis_len_keep_pkg:
  - State enum (IDLE, RUN).
  - Function keep_mask(n, bytes, msb_first).
  - Constant for the log2(C_DATA_BYTES) shift.
- One natural sub-module: cnt_to_keep_mask, a parametrised combinational count-to-mask decoder. It generalises the existing 8-byte decoder and is instantiated once.

Test Plan (all at C_DATA_BYTES=8):
- L=20, free-flowing: 3 beats with tkeep FF, FF, F0 and tlast on beat 3. Then IDLE with len_tready=1.
- L=8: single beat, tkeep=FF, tlast=1. L=9: beats FF then 80, tlast on the second.
- L=0: zero_len pulses for 1 cycle, no m_axis beats, state remains IDLE. A following L=3 yields tkeep=E0 with tlast=1.
- L=40 with m_axis_tready held low for 5 cycles after beat 2:
  - Beat 2 is held stable and s_axis_tready=0.
  - All 5 beats are delivered in order with no loss or duplication.
- rst asserted after beat 1 of L=64:
  - Next cycle m_axis_tvalid=0, busy=0, len_tready=1.
  - A new L=4 frame gives tkeep=F0 with tlast=1.
- C_KEEP_MSB_FIRST=0, L=1: tkeep=01, tlast=1. With STATS_EN, stat_frames=1 and stat_bytes=1.

Source files
------------

// File: rtl/axis_len_keep_pkg.sv
// Shared types and helpers for the length-driven AXI-Stream framer.
// Holds the framer state encoding, the count-to-keep mask helper, a popcount
// helper for the optional statistics, and the beat-size shift helper.
package axis_len_keep_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } lkg_state_e;

  // Widest beat supported; masks are built at this width and then trimmed.
  localparam int unsigned LKG_MAX_BYTES = 64;

  // Beat size of the 10GbE datapath and its log2, used by the default build.
  localparam int unsigned LKG_DEF_BYTES = 8;
  localparam int unsigned LKG_DEF_SHIFT = 3;

  // log2 of the beat size in bytes (beat size is a power of two).
  function automatic int unsigned beat_shift(input int unsigned bytes);
    return $clog2(bytes);
  endfunction

  // n contiguous ones inside a beat of 'bytes' bytes. msb_first places the
  // first valid byte at bit bytes-1, otherwise at bit 0.
  function automatic logic [LKG_MAX_BYTES-1:0] keep_mask(input int unsigned n,
                                                         input int unsigned bytes,
                                                         input bit          msb_first);
    logic [LKG_MAX_BYTES-1:0] m;
    m = {LKG_MAX_BYTES{1'b0}};
    for (int unsigned i = 0; i < LKG_MAX_BYTES; i++) begin
      if (i < bytes) begin
        if (msb_first) begin
          m[i] = (i + n >= bytes) ? 1'b1 : 1'b0;
        end else begin
          m[i] = (i < n) ? 1'b1 : 1'b0;
        end
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Number of set bits in a keep vector.
  function automatic logic [6:0] popcount(input logic [LKG_MAX_BYTES-1:0] v);
    logic [6:0] c;
    c = 7'd0;
    for (int unsigned i = 0; i < LKG_MAX_BYTES; i++) begin
      c = c + {6'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/cnt_to_keep_mask.sv
// Combinational count-to-keep decoder for a C_DATA_BYTES-wide beat.
// Counts at or above the beat size saturate to an all-ones mask, so the
// caller can feed the raw remaining-byte count straight in.
module cnt_to_keep_mask
  import axis_len_keep_pkg::*;
#(
  parameter int unsigned C_DATA_BYTES     = 8,
  parameter int unsigned C_CNT_WIDTH      = 16,
  parameter bit          C_KEEP_MSB_FIRST = 1'b1
) (
  input  logic [C_CNT_WIDTH-1:0]  cnt,
  output logic [C_DATA_BYTES-1:0] keep
);

  int unsigned              n_s;
  logic [LKG_MAX_BYTES-1:0] mask_full_s;

  // Saturate the count to the beat size and expand it into a byte mask.
  always_comb begin
    n_s         = 32'(cnt);
    if (n_s >= C_DATA_BYTES) begin
      n_s = C_DATA_BYTES;
    end else begin
      n_s = n_s;
    end
    mask_full_s = keep_mask(n_s, C_DATA_BYTES, C_KEEP_MSB_FIRST);
    keep        = mask_full_s[C_DATA_BYTES-1:0];
  end

  // Upper mask bits are always zero for beats narrower than the maximum.
  if (C_DATA_BYTES < LKG_MAX_BYTES) begin : g_trim
    logic unused_hi_s;
    assign unused_hi_s = ^mask_full_s[LKG_MAX_BYTES-1:C_DATA_BYTES];
  end

endmodule

// File: rtl/axis_len_keep_gen.sv
// Length-driven AXI-Stream framer: takes one byte-length command per frame,
// passes data beats through one registered output stage and generates
// tkeep/tlast from the running remaining-byte count.
// Optional statistics counters are enabled with AXIS_LEN_KEEP_STATS_EN.
module axis_len_keep_gen
  import axis_len_keep_pkg::*;
#(
  parameter int unsigned C_DATA_BYTES     = 8,
  parameter int unsigned C_LEN_WIDTH      = 16,
  parameter bit          C_KEEP_MSB_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [C_LEN_WIDTH-1:0]    len_tdata,
  input  logic                      len_tvalid,
  output logic                      len_tready,
  input  logic [8*C_DATA_BYTES-1:0] s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [8*C_DATA_BYTES-1:0] m_axis_tdata,
  output logic [C_DATA_BYTES-1:0]   m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      busy,
  output logic                      zero_len
`ifdef AXIS_LEN_KEEP_STATS_EN
  ,
  output logic [31:0]               stat_frames,
  output logic [31:0]               stat_bytes
`endif
);

  localparam int unsigned          C_SHIFT      = beat_shift(C_DATA_BYTES);
  localparam logic [C_LEN_WIDTH:0] C_BEAT_BYTES = {{C_LEN_WIDTH{1'b0}}, 1'b1} << C_SHIFT;

  lkg_state_e                state_r;
  lkg_state_e                state_nx_s;
  logic [C_LEN_WIDTH-1:0]    remaining_r;
  logic [C_LEN_WIDTH-1:0]    remaining_nx_s;
  logic                      len_tready_s;
  logic                      s_tready_s;
  logic                      load_s;
  logic                      last_s;
  logic                      zero_len_nx_s;
  logic                      m_hs_s;
  logic [C_DATA_BYTES-1:0]   keep_s;

  logic [8*C_DATA_BYTES-1:0] m_tdata_r;
  logic [C_DATA_BYTES-1:0]   m_tkeep_r;
  logic                      m_tlast_r;
  logic                      m_tvalid_r;
  logic                      zero_len_r;

  cnt_to_keep_mask #(
    .C_DATA_BYTES     (C_DATA_BYTES),
    .C_CNT_WIDTH      (C_LEN_WIDTH),
    .C_KEEP_MSB_FIRST (C_KEEP_MSB_FIRST)
  ) u_mask (
    .cnt  (remaining_r),
    .keep (keep_s)
  );

  assign m_hs_s = m_tvalid_r & m_axis_tready;
  assign last_s = ({1'b0, remaining_r} <= C_BEAT_BYTES);

  // Next-state, handshake and remaining-count decisions for the framer.
  always_comb begin
    state_nx_s     = state_r;
    remaining_nx_s = remaining_r;
    len_tready_s   = 1'b0;
    s_tready_s     = 1'b0;
    load_s         = 1'b0;
    zero_len_nx_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        len_tready_s = 1'b1;
        if (len_tvalid) begin
          if (len_tdata == {C_LEN_WIDTH{1'b0}}) begin
            zero_len_nx_s = 1'b1;
          end else begin
            remaining_nx_s = len_tdata;
            state_nx_s     = ST_RUN;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        s_tready_s = ~m_tvalid_r | m_axis_tready;
        if (s_axis_tvalid && s_tready_s) begin
          load_s = 1'b1;
          if (last_s) begin
            remaining_nx_s = {C_LEN_WIDTH{1'b0}};
            state_nx_s     = ST_IDLE;
          end else begin
            remaining_nx_s = remaining_r - C_BEAT_BYTES[C_LEN_WIDTH-1:0];
          end
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      default: begin
        state_nx_s     = ST_IDLE;
        remaining_nx_s = {C_LEN_WIDTH{1'b0}};
      end
    endcase
  end

  // State, remaining-count and zero-length pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      remaining_r <= {C_LEN_WIDTH{1'b0}};
      zero_len_r  <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      remaining_r <= remaining_nx_s;
      zero_len_r  <= zero_len_nx_s;
    end
  end

  // Output register: load on input handshake, drop valid on a bare drain,
  // otherwise hold the beat stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tdata_r  <= {(8*C_DATA_BYTES){1'b0}};
      m_tkeep_r  <= {C_DATA_BYTES{1'b0}};
      m_tlast_r  <= 1'b0;
      m_tvalid_r <= 1'b0;
    end else if (load_s) begin
      m_tdata_r  <= s_axis_tdata;
      m_tkeep_r  <= keep_s;
      m_tlast_r  <= last_s;
      m_tvalid_r <= 1'b1;
    end else if (m_hs_s) begin
      m_tvalid_r <= 1'b0;
    end else begin
      m_tvalid_r <= m_tvalid_r;
    end
  end

  // Ready and busy are forced low while reset is applied.
  assign len_tready    = len_tready_s & ~rst;
  assign s_axis_tready = s_tready_s & ~rst;
  assign busy          = ((state_r == ST_RUN) | m_tvalid_r) & ~rst;
  assign zero_len      = zero_len_r;
  assign m_axis_tdata  = m_tdata_r;
  assign m_axis_tkeep  = m_tkeep_r;
  assign m_axis_tlast  = m_tlast_r;
  assign m_axis_tvalid = m_tvalid_r;

`ifdef AXIS_LEN_KEEP_STATS_EN
  logic [31:0]              stat_frames_r;
  logic [31:0]              stat_bytes_r;
  logic [LKG_MAX_BYTES-1:0] keep_ext_s;

  // Zero-extend the held keep to the popcount width.
  always_comb begin
    keep_ext_s                    = {LKG_MAX_BYTES{1'b0}};
    keep_ext_s[C_DATA_BYTES-1:0]  = m_tkeep_r;
  end

  // Frame and byte counters, advanced on each downstream handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames_r <= 32'd0;
      stat_bytes_r  <= 32'd0;
    end else if (m_hs_s) begin
      stat_frames_r <= stat_frames_r + {31'd0, m_tlast_r};
      stat_bytes_r  <= stat_bytes_r + {25'd0, popcount(keep_ext_s)};
    end else begin
      stat_frames_r <= stat_frames_r;
      stat_bytes_r  <= stat_bytes_r;
    end
  end

  assign stat_frames = stat_frames_r;
  assign stat_bytes  = stat_bytes_r;
`endif

endmodule

// File: tb/tb_axis_len_keep_gen.sv
// Self-checking bench for axis_len_keep_gen at 8 bytes per beat.
// Expected beats are pushed to a queue when an input beat is accepted and
// popped when the DUT presents the beat downstream.
module tb_axis_len_keep_gen;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;

  logic [15:0] len_tdata;
  logic        len_tvalid, len_tready;
  logic [63:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast, m_tvalid, m_tready;
  logic        busy, zero_len;

  logic [15:0] l_len_tdata;
  logic        l_len_tvalid, l_len_tready;
  logic [63:0] l_s_tdata;
  logic        l_s_tvalid, l_s_tready;
  logic [63:0] l_m_tdata;
  logic [7:0]  l_m_tkeep;
  logic        l_m_tlast, l_m_tvalid, l_m_tready;
  logic        l_busy, l_zero_len;

`ifdef AXIS_LEN_KEEP_STATS_EN
  logic [31:0] stat_frames, stat_bytes, l_stat_frames, l_stat_bytes;
`endif

  beat_t exp_q[$];
  beat_t l_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    exp_frames = 0;
  int    exp_bytes  = 0;

  always #5 clk = ~clk;

  axis_len_keep_gen #(.C_DATA_BYTES(8), .C_LEN_WIDTH(16), .C_KEEP_MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .len_tdata(len_tdata), .len_tvalid(len_tvalid), .len_tready(len_tready),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .busy(busy), .zero_len(zero_len)
`ifdef AXIS_LEN_KEEP_STATS_EN
    , .stat_frames(stat_frames), .stat_bytes(stat_bytes)
`endif
  );

  axis_len_keep_gen #(.C_DATA_BYTES(8), .C_LEN_WIDTH(16), .C_KEEP_MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst),
    .len_tdata(l_len_tdata), .len_tvalid(l_len_tvalid), .len_tready(l_len_tready),
    .s_axis_tdata(l_s_tdata), .s_axis_tvalid(l_s_tvalid), .s_axis_tready(l_s_tready),
    .m_axis_tdata(l_m_tdata), .m_axis_tkeep(l_m_tkeep), .m_axis_tlast(l_m_tlast),
    .m_axis_tvalid(l_m_tvalid), .m_axis_tready(l_m_tready),
    .busy(l_busy), .zero_len(l_zero_len)
`ifdef AXIS_LEN_KEEP_STATS_EN
    , .stat_frames(l_stat_frames), .stat_bytes(l_stat_bytes)
`endif
  );

  // Reference mask: r valid bytes out of 8, MSB-first or LSB-first.
  function automatic logic [7:0] ref_keep(input int r, input bit msb);
    logic [7:0] k;
    if (r >= 8) begin
      k = 8'hFF;
    end else begin
      k = 8'((16'd1 << r) - 16'd1);
      if (msb) k = k << (8 - r);
    end
    return k;
  endfunction

  function automatic int ones8(input logic [7:0] k);
    int c;
    c = 0;
    for (int i = 0; i < 8; i++) c += int'(k[i]);
    return c;
  endfunction

  // Run one frame of 'len' bytes through the MSB-first DUT. Downstream ready
  // is dropped for stall_cyc cycles once stall_after beats have been received.
  task automatic run_frame(input int len, input int stall_after, input int stall_cyc);
    int    nbeats;
    int    sent, recv, rem, stall_left;
    bit    cmd_done, prev_load, gap_chk, stalling, done;
    logic [63:0] cur_data;
    beat_t e;
    nbeats     = (len + 7) / 8;
    sent       = 0;
    recv       = 0;
    rem        = len;
    stall_left = stall_cyc;
    cmd_done   = 1'b0;
    prev_load  = 1'b0;
    gap_chk    = 1'b0;
    done       = 1'b0;
    cur_data   = {$urandom, $urandom};
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      len_tvalid = !cmd_done;
      len_tdata  = 16'(len);
      s_tvalid   = cmd_done && (sent < nbeats);
      s_tdata    = cur_data;
      stalling   = (recv == stall_after) && (stall_left > 0);
      m_tready   = !stalling;
      #1;
      if (prev_load) begin
        n_checks++;
        if (m_tvalid !== 1'b1)
          $display("FAIL latency len=%0d: m_tvalid=%b, required 1", len, m_tvalid);
        if (m_tvalid !== 1'b1) n_fail++;
      end
      if (gap_chk) begin
        n_checks++;
        if (len_tready !== 1'b1) begin
          n_fail++;
          $display("FAIL gap_ready len=%0d: len_tready=%b, required 1", len, len_tready);
        end
        gap_chk = 1'b0;
      end
      if (stalling) begin
        stall_left--;
        n_checks++;
        if (m_tvalid !== 1'b1 || exp_q.size() == 0 || m_tdata !== exp_q[0].data ||
            m_tkeep !== exp_q[0].keep) begin
          n_fail++;
          $display("FAIL stall_hold len=%0d: valid=%b data=%h keep=%h, required held front beat",
                   len, m_tvalid, m_tdata, m_tkeep);
        end
        n_checks++;
        if (s_tready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_sready len=%0d: s_tready=%b, required 0", len, s_tready);
        end
      end
      prev_load = 1'b0;
      if (m_tvalid && m_tready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat len=%0d: unexpected beat data=%h, required none", len, m_tdata);
        end else begin
          e = exp_q.pop_front();
          if (m_tdata !== e.data || m_tkeep !== e.keep || m_tlast !== e.last) begin
            n_fail++;
            $display("FAIL beat len=%0d idx=%0d: data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                     len, recv, m_tdata, m_tkeep, m_tlast, e.data, e.keep, e.last);
          end
          exp_frames += int'(e.last);
          exp_bytes  += ones8(e.keep);
        end
        recv++;
      end
      if (s_tvalid && s_tready) begin
        e.data = cur_data;
        e.keep = ref_keep(rem, 1'b1);
        e.last = (rem <= 8);
        exp_q.push_back(e);
        if (rem <= 8) begin
          n_checks++;
          if (len_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL run_ready len=%0d: len_tready=%b on last load, required 0", len, len_tready);
          end
          rem     = 0;
          gap_chk = 1'b1;
        end else begin
          rem -= 8;
        end
        sent++;
        prev_load = 1'b1;
        cur_data  = {$urandom, $urandom};
      end
      if (len_tvalid && len_tready) cmd_done = 1'b1;
      if (cmd_done && sent == nbeats && recv == nbeats) done = 1'b1;
    end
    @(negedge clk);
    len_tvalid = 1'b0;
    s_tvalid   = 1'b0;
    m_tready   = 1'b1;
    #1;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout len=%0d: sent=%0d recv=%0d, required %0d beats", len, sent, recv, nbeats);
    end else if (m_tvalid !== 1'b0 || busy !== 1'b0 || len_tready !== 1'b1 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL post_frame len=%0d: valid=%b busy=%b len_tready=%b queue=%0d, required 0 0 1 0",
               len, m_tvalid, busy, len_tready, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    len_tvalid = 1'b0; len_tdata = 16'd0; s_tvalid = 1'b0; s_tdata = 64'd0; m_tready = 1'b1;
    l_len_tvalid = 1'b0; l_len_tdata = 16'd0; l_s_tvalid = 1'b0; l_s_tdata = 64'd0; l_m_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (len_tready !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL in_reset: len_tready=%b busy=%b, required 0 0", len_tready, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tkeep !== 8'h00 || m_tdata !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b last=%b keep=%h data=%h, required all 0",
               m_tvalid, m_tlast, m_tkeep, m_tdata);
    end
    n_checks++;
    if (zero_len !== 1'b0 || busy !== 1'b0 || len_tready !== 1'b1 || s_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: zero_len=%b busy=%b len_tready=%b s_tready=%b, required 0 0 1 0",
               zero_len, busy, len_tready, s_tready);
    end
  endtask

  task automatic test_free_flow();
    run_frame(20, -1, 0);
  endtask

  task automatic test_back_to_back();
    run_frame(8, -1, 0);
    run_frame(9, -1, 0);
  endtask

  task automatic test_zero_len();
    @(negedge clk);
    len_tvalid = 1'b1; len_tdata = 16'd0; s_tvalid = 1'b1; s_tdata = 64'hDEAD_BEEF_0000_0001;
    #1;
    n_checks++;
    if (len_tready !== 1'b1 || s_tready !== 1'b0) begin
      n_fail++;
      $display("FAIL zl_idle: len_tready=%b s_tready=%b, required 1 0", len_tready, s_tready);
    end
    @(negedge clk);
    len_tvalid = 1'b0;
    #1;
    n_checks++;
    if (zero_len !== 1'b1 || m_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zl_pulse: zero_len=%b valid=%b busy=%b, required 1 0 0", zero_len, m_tvalid, busy);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (zero_len !== 1'b0 || m_tvalid !== 1'b0 || len_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL zl_after: zero_len=%b valid=%b len_tready=%b, required 0 0 1",
               zero_len, m_tvalid, len_tready);
    end
    s_tvalid = 1'b0;
    run_frame(3, -1, 0);
  endtask

  task automatic test_stall();
    run_frame(40, 1, 5);
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    len_tvalid = 1'b1; len_tdata = 16'd64;
    @(negedge clk);
    len_tvalid = 1'b0; s_tvalid = 1'b1; s_tdata = 64'h1122_3344_5566_7788; m_tready = 1'b0;
    #1;
    n_checks++;
    if (s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_sready: s_tready=%b, required 1", s_tready);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    #1;
    n_checks++;
    if (m_tvalid !== 1'b1 || busy !== 1'b1 || m_tkeep !== 8'hFF || m_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_held: valid=%b busy=%b keep=%h last=%b, required 1 1 ff 0",
               m_tvalid, busy, m_tkeep, m_tlast);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0 || len_tready !== 1'b1 || m_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b busy=%b len_tready=%b last=%b, required 0 0 1 0",
               m_tvalid, busy, len_tready, m_tlast);
    end
    m_tready = 1'b1;
`ifdef AXIS_LEN_KEEP_STATS_EN
    exp_frames = 0;
    exp_bytes  = 0;
`endif
    run_frame(4, -1, 0);
  endtask

  task automatic test_lsb_first();
    beat_t e;
    @(negedge clk);
    l_len_tvalid = 1'b1; l_len_tdata = 16'd1;
    @(negedge clk);
    l_len_tvalid = 1'b0; l_s_tvalid = 1'b1; l_s_tdata = {$urandom, $urandom};
    #1;
    if (l_s_tvalid && l_s_tready) begin
      e.data = l_s_tdata;
      e.keep = ref_keep(1, 1'b0);
      e.last = 1'b1;
      l_q.push_back(e);
    end
    @(negedge clk);
    l_s_tvalid = 1'b0;
    #1;
    n_checks++;
    if (l_q.size() == 0 || l_m_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL lsb_beat: valid=%b queue=%0d, required beat present", l_m_tvalid, l_q.size());
    end else begin
      e = l_q.pop_front();
      if (l_m_tdata !== e.data || l_m_tkeep !== e.keep || l_m_tlast !== e.last) begin
        n_fail++;
        $display("FAIL lsb_beat: data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                 l_m_tdata, l_m_tkeep, l_m_tlast, e.data, e.keep, e.last);
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (l_m_tvalid !== 1'b0 || l_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lsb_done: valid=%b busy=%b, required 0 0", l_m_tvalid, l_busy);
    end
`ifdef AXIS_LEN_KEEP_STATS_EN
    n_checks++;
    if (l_stat_frames !== 32'd1 || l_stat_bytes !== 32'd1) begin
      n_fail++;
      $display("FAIL lsb_stats: frames=%0d bytes=%0d, required 1 1", l_stat_frames, l_stat_bytes);
    end
    n_checks++;
    if (stat_frames !== 32'(exp_frames) || stat_bytes !== 32'(exp_bytes)) begin
      n_fail++;
      $display("FAIL msb_stats: frames=%0d bytes=%0d, required %0d %0d",
               stat_frames, stat_bytes, exp_frames, exp_bytes);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_free_flow();
    test_back_to_back();
    test_zero_len();
    test_stall();
    test_reset_midframe();
    test_lsb_first();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
